// File: rtl/score_keeper.sv
// Score bus source: counts apple events, saturates, tracks high score and speed level,
// and issues the one-cycle sync_reset pulse that clears score consumers at game start.
module score_keeper #(
  parameter int unsigned MaxScore  = 99,
  parameter int unsigned LevelStep = 10,
  parameter int unsigned MaxLevel  = 7
) (
  input  logic       clock_25_i,
  input  logic       reset_ni,
  input  logic       start_game_i,
  input  logic       apple_eaten_i,
  input  logic       collision_i,
  output logic [6:0] score_o,
  output logic [6:0] high_score_o,
  output logic       sync_reset_o,
  output logic       game_active_o,
  output logic       new_record_o,
  output logic [2:0] speed_level_o
);

  localparam int unsigned SubW = (LevelStep > 1) ? $clog2(LevelStep) : 1;
  localparam logic [6:0]      MaxScoreL = 7'(MaxScore);
  localparam logic [SubW-1:0] SubLast   = SubW'(LevelStep - 1);
  localparam logic [2:0]      MaxLevelL = 3'(MaxLevel);

  typedef enum logic [1:0] {StIdle, StClear, StPlay, StOver} state_e;

  state_e          state_q;
  logic [6:0]      score_q, high_score_q, hs_base_q;
  logic [2:0]      level_q;
  logic [SubW-1:0] sub_q;
  logic            sync_reset_q, game_active_q, new_record_q;

  logic armed_q;
  logic start_q, apple_q, coll_q;
  logic start_rise_q, apple_rise_q, coll_rise_q;

  logic [6:0] score_inc;
  assign score_inc = score_q + 7'd1;

  // armed_q suppresses the first sample after reset so a level held through reset is no edge.
  always_ff @(posedge clock_25_i or negedge reset_ni) begin
    if (!reset_ni) begin
      armed_q      <= 1'b0;
      start_q      <= 1'b0;
      apple_q      <= 1'b0;
      coll_q       <= 1'b0;
      start_rise_q <= 1'b0;
      apple_rise_q <= 1'b0;
      coll_rise_q  <= 1'b0;
    end else begin
      armed_q      <= 1'b1;
      start_q      <= start_game_i;
      apple_q      <= apple_eaten_i;
      coll_q       <= collision_i;
      start_rise_q <= armed_q & start_game_i & ~start_q;
      apple_rise_q <= armed_q & apple_eaten_i & ~apple_q;
      coll_rise_q  <= armed_q & collision_i & ~coll_q;
    end
  end

  always_ff @(posedge clock_25_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      score_q       <= '0;
      high_score_q  <= '0;
      hs_base_q     <= '0;
      level_q       <= '0;
      sub_q         <= '0;
      sync_reset_q  <= 1'b0;
      game_active_q <= 1'b0;
      new_record_q  <= 1'b0;
    end else begin
      sync_reset_q <= 1'b0;
      unique case (state_q)
        StIdle, StOver: begin
          // Clear on entry to StClear so score reads 0 exactly while sync_reset is high.
          if (start_rise_q) begin
            state_q      <= StClear;
            sync_reset_q <= 1'b1;
            score_q      <= '0;
            level_q      <= '0;
            sub_q        <= '0;
            new_record_q <= 1'b0;
            hs_base_q    <= high_score_q;
          end
        end
        StClear: begin
          state_q       <= StPlay;
          game_active_q <= 1'b1;
        end
        StPlay: begin
          if (apple_rise_q && (score_q < MaxScoreL)) begin
            score_q <= score_inc;
            if (score_inc > high_score_q) high_score_q <= score_inc;
            if (score_inc > hs_base_q)    new_record_q <= 1'b1;
            if (sub_q == SubLast) begin
              sub_q <= '0;
              if (level_q < MaxLevelL) level_q <= level_q + 3'd1;
            end else begin
              sub_q <= sub_q + SubW'(1);
            end
          end
          if (coll_rise_q) begin
            state_q       <= StOver;
            game_active_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign score_o       = score_q;
  assign high_score_o  = high_score_q;
  assign sync_reset_o  = sync_reset_q;
  assign game_active_o = game_active_q;
  assign new_record_o  = new_record_q;
  assign speed_level_o = level_q;

endmodule
